fir_tap_accumulator: RTL and testbench
======================================

// Module: fir_tap_accumulator
// PURPOSE
//  Sequencing/accumulation stage for the FIR filter; sits directly upstream and downstream of the
//  shared pipelined multiplier. Accepts one input sample, shifts it into a TAPS-deep delay line,
//  and issues one multiply per tap (x[k]*c[k]) over the start/done handshake.
//  Sums the signed products and presents one filter output per accepted sample on a valid/ready port.
// PARAMETERS
//  WIDTH      16                         sample/coefficient width (signed); multiplier WIDTH matches
//  TAPS       8                          number of filter taps (>=2)
//  ACC_WIDTH  2*WIDTH+$clog2(TAPS)       accumulator/output width; no overflow possible by construction
// PORTS
//  clk          in   1             single clock, rising edge
//  reset        in   1             asynchronous, active-high
//  in_valid     in   1             input sample valid
//  in_sample    in   WIDTH         signed input sample
//  in_ready     out  1             high only in IDLE
//  coef_we      in   1             coefficient write strobe (honoured in IDLE only)
//  coef_addr    in   $clog2(TAPS)  coefficient index; addr>=TAPS ignored
//  coef_data    in   WIDTH         signed coefficient
//  mul_inp1     out  WIDTH         multiplier operand = x[idx]
//  mul_inp2     out  WIDTH         multiplier operand = c[idx]
//  mul_start    out  1             one-cycle start pulse to multiplier
//  mul_done     in   1             multiplier done (1 cycle)
//  mul_product  in   2*WIDTH       multiplier result; valid in mul_done cycle; signed
//  out_valid    out  1             filter output valid
//  out_data     out  ACC_WIDTH     signed sum over k of x[k]*c[k]
//  out_ready    in   1             downstream accepts out_data
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, acc=0, delay line=0, coefs=0; in_ready=1, mul_start=0, out_valid=0,
//   mul_inp1/2=0, out_data=0. Reset mid-operation aborts immediately; no output for the aborted sample.
//   The top level drives the multiplier's active-low reset from the inverse of the same reset.
//  FSM:
//   IDLE   : in_ready=1. in_valid -> x[0]<=in_sample, x[k]<=x[k-1], acc<=0, idx<=0 -> ISSUE.
//   ISSUE  : mul_start=1 for exactly this cycle; operands x[idx]/c[idx] driven -> WAIT.
//   WAIT   : operands held stable (multiplier is combinational to its output register).
//            On mul_done: acc<=acc+sext(mul_product).
//            If idx==TAPS-1 -> OUT; else idx<=idx+1 -> ISSUE.
//   OUT    : out_valid=1, out_data=acc held. On out_ready -> IDLE; in_ready rises the next cycle.
//  Timing: the multiplier asserts done 5 cycles after the start edge, so each tap costs 6 cycles.
//   out_valid rises 6*TAPS+1 edges after the accepting edge. Next mul_start never precedes the
//   multiplier's return to idle.
//  Product is treated as signed two's complement and sign-extended to ACC_WIDTH; acc never wraps.
//  mul_done outside WAIT is ignored. coef_we outside IDLE is ignored; an IDLE coefficient write and
//   a sample accept in the same cycle both take effect (new coef is used for that sample).
//  out_ready low holds out_valid/out_data stable indefinitely; no sample is accepted meanwhile.
// STRUCTURE
//  fir_pkg: state enum {IDLE,ISSUE,WAIT,OUT}, MUL_LATENCY=5 constant, acc-width helper function.
//  Sub-module fir_delay_line (TAPS x WIDTH shift register with shift-enable and indexed read).
//  Coefficient RAM, FSM, idx counter and accumulator stay in the top module.
// TESTING (WIDTH=8, TAPS=4, real Multiplier instance)
//  Coefs {1,2,3,4}, samples 1,0,0,0 -> outputs 1,2,3,4 (impulse response); each out_valid 25 cycles after accept.
//  All coefs -128, four samples of -128 -> final output 65536 (no overflow, sign handled).
//  Coefs {1,-1,1,-1}, samples 5,7 -> outputs 5, 2.
//  out_ready held low 10 cycles in OUT -> out_valid/out_data stable, in_ready=0, in_valid ignored.
//  Reset pulsed while in WAIT on tap 2 -> in_ready=1 next cycle, no out_valid, delay line and coefs zeroed.
//  coef_we during WAIT and spurious mul_done in IDLE -> no coefficient change, acc/state unchanged.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg
//   Shared types and constants for the FIR tap accumulator.
//   - fir_state_t : sequencing FSM states
//   - MUL_LATENCY : start-edge to done latency of the shared multiplier
//   - acc_width() : accumulator width that cannot overflow for a given
//                   sample width and tap count
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } fir_state_t;

  // The multiplier raises done in the 5th cycle after it samples start, so
  // one tap (issue cycle + wait) costs MUL_LATENCY + 1 cycles.
  localparam int MUL_LATENCY = 5;

  // Full-precision product plus one bit per doubling of the tap count.
  function automatic int acc_width(input int width, input int taps);
    return 2 * width + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line
//   TAPS-deep shift register of WIDTH-bit samples. A new sample enters at
//   index 0 and older samples move up one slot; the oldest is dropped.
//   Ports:
//     clk, reset   clock / asynchronous active-high reset (clears the line)
//     shift_en     shift shift_in into slot 0 this cycle
//     shift_in     incoming sample
//     rd_idx       slot to read (0 = newest)
//     rd_data      contents of slot rd_idx (combinational read)
module fir_delay_line #(
  parameter int WIDTH = 16,
  parameter int TAPS  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    shift_en,
  input  logic [WIDTH-1:0]        shift_in,
  input  logic [$clog2(TAPS)-1:0] rd_idx,
  output logic [WIDTH-1:0]        rd_data
);

  logic [TAPS-1:0][WIDTH-1:0] line;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         line <= '0;
    else if (shift_en) line <= {line[TAPS-2:0], shift_in};
  end

  assign rd_data = line[rd_idx];

endmodule

// File: rtl/fir_tap_accumulator.sv
// fir_tap_accumulator
//   Sequencing and accumulation around a shared pipelined multiplier.
//   Each accepted sample is shifted into the delay line, then one multiply
//   per tap (x[k]*c[k]) is issued with a one-cycle start pulse and its
//   product is summed into a sign-extended accumulator. The finished sum is
//   offered on a valid/ready port; no new sample is taken until it is
//   consumed.
//   Ports:
//     clk, reset                   clock / asynchronous active-high reset
//     in_valid, in_sample, in_ready  sample input (ready only while idle)
//     coef_we, coef_addr, coef_data  coefficient write, honoured while idle
//     mul_inp1, mul_inp2           multiplier operands x[idx], c[idx]
//     mul_start                    one-cycle start pulse
//     mul_done, mul_product        multiplier result handshake
//     out_valid, out_data, out_ready filter output
module fir_tap_accumulator
  import fir_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int TAPS      = 8,
  parameter int ACC_WIDTH = acc_width(WIDTH, TAPS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_sample,
  output logic                    in_ready,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [WIDTH-1:0]        coef_data,
  output logic [WIDTH-1:0]        mul_inp1,
  output logic [WIDTH-1:0]        mul_inp2,
  output logic                    mul_start,
  input  logic                    mul_done,
  input  logic [2*WIDTH-1:0]      mul_product,
  output logic                    out_valid,
  output logic [ACC_WIDTH-1:0]    out_data,
  input  logic                    out_ready
);

  localparam int                IDX_W    = $clog2(TAPS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(TAPS - 1);
  localparam logic [IDX_W:0]    TAPS_CNT = (IDX_W + 1)'(TAPS);

  fir_state_t                 state;
  logic [IDX_W-1:0]           idx;
  logic [ACC_WIDTH-1:0]       acc;
  logic [TAPS-1:0][WIDTH-1:0] coef;

  logic                       accept;
  logic                       coef_hit;
  logic [WIDTH-1:0]           x_rd;
  logic [ACC_WIDTH-1:0]       prod_sext;

  assign accept   = (state == ST_IDLE) && in_valid;
  // Out-of-range addresses only exist when TAPS is not a power of two.
  assign coef_hit = coef_we && (state == ST_IDLE) && ({1'b0, coef_addr} < TAPS_CNT);

  assign prod_sext = {{(ACC_WIDTH - 2*WIDTH){mul_product[2*WIDTH-1]}}, mul_product};

  fir_delay_line #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_delay (
    .clk      (clk),
    .reset    (reset),
    .shift_en (accept),
    .shift_in (in_sample),
    .rd_idx   (idx),
    .rd_data  (x_rd)
  );

  // Operands follow idx directly. idx only moves on the done edge, so they
  // are stable for the whole issue + wait window of a tap.
  assign mul_inp1 = x_rd;
  assign mul_inp2 = coef[idx];
  assign out_data = acc;

  // Coefficient store. A write in the accept cycle lands on the same edge
  // as the shift, so the first issue already sees the new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         coef <= '0;
    else if (coef_hit) coef[coef_addr] <= coef_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      mul_start <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            acc       <= '0;
            idx       <= '0;
            in_ready  <= 1'b0;
            mul_start <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mul_start <= 1'b0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mul_done) begin
            acc <= acc + prod_sext;
            if (idx == LAST_IDX) begin
              out_valid <= 1'b1;
              state     <= ST_OUT;
            end else begin
              // The done cycle is the multiplier's last busy cycle, so the
              // next start lands exactly as it returns to idle.
              idx       <= idx + 1'b1;
              mul_start <= 1'b1;
              state     <= ST_ISSUE;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          mul_start <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Bench for fir_tap_accumulator (WIDTH=8, TAPS=4) with a behavioural
// multiplier: it samples start, raises done for one cycle in the 5th cycle
// after that edge, and computes the product from the operands seen then.
module tb_fir_tap_accumulator;

  localparam int WIDTH = 8;
  localparam int TAPS  = 4;
  localparam int AW    = 2 * WIDTH + $clog2(TAPS);

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic [WIDTH-1:0]        in_sample;
  logic                    in_ready;
  logic                    coef_we;
  logic [$clog2(TAPS)-1:0] coef_addr;
  logic [WIDTH-1:0]        coef_data;
  logic [WIDTH-1:0]        mul_inp1, mul_inp2;
  logic                    mul_start;
  logic                    mul_done;
  logic [2*WIDTH-1:0]      mul_product;
  logic                    out_valid;
  logic [AW-1:0]           out_data;
  logic                    out_ready;

  always #5 clk = ~clk;

  fir_tap_accumulator #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
    .clk         (clk),
    .reset       (rst),
    .in_valid    (in_valid),
    .in_sample   (in_sample),
    .in_ready    (in_ready),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .mul_inp1    (mul_inp1),
    .mul_inp2    (mul_inp2),
    .mul_start   (mul_start),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
  );

  // ---------------- multiplier model ----------------
  int               m_cnt;
  logic             m_done;
  logic [2*WIDTH-1:0] m_prod;
  int               busy_err;
  logic             inj_done;
  logic [2*WIDTH-1:0] inj_prod;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_prod <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 4) begin
        m_done <= 1'b1;
        m_prod <= $signed(mul_inp1) * $signed(mul_inp2);
        m_cnt  <= 0;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt + 1;
      end
      if (mul_start) begin
        if (m_cnt != 0 || m_done) busy_err <= busy_err + 1;
        m_cnt <= 1;
      end
    end
  end

  assign mul_done    = m_done | inj_done;
  assign mul_product = inj_done ? inj_prod : m_prod;

  // ---------------- reference model ----------------
  int hist[TAPS];
  int cf[TAPS];

  function automatic longint model_out();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(hist[k]) * longint'(cf[k]);
    return s;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      hist[k] = 0;
      cf[k]   = 0;
    end
  endtask

  task automatic model_push(input int s);
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
  endtask

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint outv();
    return longint'($signed(out_data));
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic write_coef(input int a, input int d);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = ($clog2(TAPS))'(a);
    coef_data = WIDTH'(d);
    @(posedge clk);
    cf[a] = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
    write_coef(0, c0);
    write_coef(1, c1);
    write_coef(2, c2);
    write_coef(3, c3);
  endtask

  // One sample through the filter. wr: coefficient write in the accept
  // cycle. poke: coefficient write attempts while busy (must be ignored).
  // hold: cycles out_ready is kept low once the output appears.
  task automatic run_sample(input int s, input bit wr, input int wa, input int wd,
                            input bit poke, input int hold);
    int n;
    bit seen;
    longint exp, held;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_sample = WIDTH'(s);
    if (wr) begin
      coef_we   = 1'b1;
      coef_addr = ($clog2(TAPS))'(wa);
      coef_data = WIDTH'(wd);
    end
    out_ready = (hold == 0);
    @(posedge clk);
    if (wr) cf[wa] = wd;
    model_push(s);
    exp = model_out();
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    n = 1;
    chk("in_ready_busy", in_ready, 0);
    if (poke) begin
      coef_we   = 1'b1;
      coef_addr = ($clog2(TAPS))'($urandom_range(0, TAPS - 1));
      coef_data = WIDTH'($urandom);
    end
    seen = 1'b0;
    while (!seen && n < 300) begin
      if (out_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
        if (n == 12) coef_we = 1'b0;
      end
    end
    coef_we = 1'b0;
    chk("latency", n, 6 * TAPS + 1);
    chk("out_data", outv(), exp);
    if (hold > 0) begin
      held = outv();
      for (int i = 0; i < hold; i++) begin
        in_valid  = 1'b1;
        in_sample = WIDTH'($urandom);
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_data", outv(), held);
        chk("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    longint held, o;
    int starts, n;
    bit ov;
    rst = 1'b1; in_valid = 1'b0; in_sample = '0; coef_we = 1'b0;
    coef_addr = '0; coef_data = '0; out_ready = 1'b1;
    inj_done = 1'b0; inj_prod = '0; busy_err = 0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_inp1", mul_inp1, 0);
    chk("rst_inp2", mul_inp2, 0);
    chk("rst_out_data", outv(), 0);
    rst = 1'b0;

    // impulse response
    set_coefs(1, 2, 3, 4);
    run_sample(1, 0, 0, 0, 0, 0);
    chk("impulse0", outv(), 1);
    run_sample(0, 0, 0, 0, 0, 0);
    chk("impulse1", outv(), 2);
    run_sample(0, 0, 0, 0, 0, 0);
    run_sample(0, 0, 0, 0, 0, 0);
    chk("impulse3", outv(), 4);

    // extreme negative values
    set_coefs(-128, -128, -128, -128);
    for (int i = 0; i < 4; i++) run_sample(-128, 0, 0, 0, 0, 0);
    chk("extreme", outv(), 65536);

    // alternating coefficients from a clean history
    do_reset();
    set_coefs(1, -1, 1, -1);
    run_sample(5, 0, 0, 0, 0, 0);
    chk("alt0", outv(), 5);
    run_sample(7, 0, 0, 0, 0, 0);
    chk("alt1", outv(), 2);

    // backpressure in OUT
    run_sample(-3, 0, 0, 0, 0, 10);

    // coefficient writes while busy, then spurious done in IDLE
    run_sample(11, 0, 0, 0, 1, 0);
    run_sample(-9, 0, 0, 0, 1, 0);
    held = outv();
    @(negedge clk);
    inj_done = 1'b1;
    inj_prod = 16'h1234;
    @(negedge clk);
    inj_done = 1'b0;
    @(negedge clk);
    chk("spurious_acc", outv(), held);
    chk("spurious_ready", in_ready, 1);
    chk("spurious_start", mul_start, 0);
    run_sample(4, 0, 0, 0, 0, 0);

    // same-cycle coefficient write and accept
    run_sample(6, 1, 0, 37, 0, 0);

    // reset in WAIT on tap 2
    set_coefs(13, -7, 22, 5);
    @(negedge clk);
    in_valid = 1'b1; in_sample = WIDTH'(50);
    @(negedge clk);
    in_valid = 1'b0;
    starts = 0; n = 0;
    while (starts < 3 && n < 200) begin
      if (mul_start) starts++;
      if (starts < 3) begin
        @(negedge clk);
        n++;
      end
    end
    chk("reach_tap2", starts, 3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", outv(), 0);
    rst = 1'b0;
    model_clear();
    ov = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) ov = 1'b1;
    end
    chk("abort_no_output", ov, 0);
    run_sample(77, 0, 0, 0, 0, 0);
    chk("coefs_zeroed", outv(), 0);
    set_coefs(3, 5, 9, -11);
    run_sample(2, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 2) == 0)
        write_coef($urandom_range(0, TAPS - 1), int'($urandom_range(0, 255)) - 128);
      run_sample(int'($urandom_range(0, 255)) - 128, $urandom_range(0, 3) == 0,
                 $urandom_range(0, TAPS - 1), int'($urandom_range(0, 255)) - 128,
                 $urandom_range(0, 3) == 0, ($urandom_range(0, 4) == 0) ? 3 : 0);
    end

    chk("mul_overlap", busy_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
